// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control
//
// Main control FSM for the multicycle MIPS datapath. Decodes the IR opcode
// and steps each instruction through fetch, decode, execute, memory and
// writeback cycles. It drives the datapath mux selects, the enables and the
// 4-bit alu_op consumed by the ALU control stage. It also counts retired
// instructions.
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous active-low reset
//   opcode        IR[31:26], sampled in DECODE and MEM_ADDR
//   mem_ready     memory completes the current access this cycle
//   pc_write      unconditional PC load
//   pc_write_cond PC load qualified by ALU zero (branch)
//   i_or_d        memory address select (0 = PC, 1 = ALUOut)
//   mem_read      memory read request
//   mem_write     memory write request
//   ir_write      IR load
//   mem_to_reg    register write data select (1 = MDR, 0 = ALUOut)
//   reg_dst       destination register select (1 = rd, 0 = rt)
//   reg_write     register file write enable
//   alu_src_a     ALU A select (0 = PC, 1 = A)
//   alu_src_b     ALU B select (B / 4 / imm / imm<<2)
//   pc_source     PC source select (ALU / ALUOut / jump target)
//   alu_op        0000 add, 0001 subtract, 0010 R-type funct decode
//   illegal_op    one-cycle pulse on an unknown opcode in DECODE
//   state         current state encoding, for debug
//   retired       retired-instruction count, wraps modulo 2^CNT_W

module mips_multicycle_control #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       pc_source,
    output logic [3:0]       alu_op,
    output logic             illegal_op,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] retired
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EX   = 4'd10,
        S_ADDI_WB   = 4'd11
    } state_t;

    state_t cur_state;
    state_t next_state;
    logic   retire;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_state <= S_FETCH;
        end else begin
            cur_state <= next_state;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retired <= '0;
        end else if (retire) begin
            retired <= retired + CNT_ONE;
        end
    end

    // Every output decode sits under 'if (rst)' so the whole control word
    // reads zero while reset is held. The moment reset releases, FETCH's
    // read request appears without waiting for a clock edge.
    always_comb begin
        next_state    = S_FETCH;
        retire        = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        pc_source     = 2'b00;
        alu_op        = 4'b0000;
        illegal_op    = 1'b0;

        if (rst) begin
            case (cur_state)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    // IR and PC+4 load only on the cycle the read completes.
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                    next_state = mem_ready ? S_DECODE : S_FETCH;
                end
                S_DECODE: begin
                    alu_src_b = 2'b11;
                    case (opcode)
                        OP_LW, OP_SW: next_state = S_MEM_ADDR;
                        OP_RTYPE:     next_state = S_EXECUTE;
                        OP_BEQ:       next_state = S_BRANCH;
                        OP_J:         next_state = S_JUMP;
                        OP_ADDI:      next_state = S_ADDI_EX;
                        default: begin
                            illegal_op = 1'b1;
                            next_state = S_FETCH;
                        end
                    endcase
                end
                S_MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    if (opcode == OP_LW) begin
                        next_state = S_MEM_READ;
                    end else if (opcode == OP_SW) begin
                        next_state = S_MEM_WRITE;
                    end else begin
                        next_state = S_FETCH;
                    end
                end
                S_MEM_READ: begin
                    mem_read   = 1'b1;
                    i_or_d     = 1'b1;
                    next_state = mem_ready ? S_MEM_WB : S_MEM_READ;
                end
                S_MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    retire     = 1'b1;
                end
                S_MEM_WRITE: begin
                    mem_write  = 1'b1;
                    i_or_d     = 1'b1;
                    retire     = mem_ready;
                    next_state = mem_ready ? S_FETCH : S_MEM_WRITE;
                end
                S_EXECUTE: begin
                    alu_src_a  = 1'b1;
                    alu_op     = 4'b0010;
                    next_state = S_R_WB;
                end
                S_R_WB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                    retire    = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = 4'b0001;
                    pc_write_cond = 1'b1;
                    pc_source     = 2'b01;
                    retire        = 1'b1;
                end
                S_JUMP: begin
                    pc_write  = 1'b1;
                    pc_source = 2'b10;
                    retire    = 1'b1;
                end
                S_ADDI_EX: begin
                    alu_src_a  = 1'b1;
                    alu_src_b  = 2'b10;
                    next_state = S_ADDI_WB;
                end
                S_ADDI_WB: begin
                    reg_write = 1'b1;
                    retire    = 1'b1;
                end
                default: begin
                    next_state = S_FETCH;
                end
            endcase
        end
    end

    assign state = cur_state;

endmodule
